// File: rtl/strassen_pkg.sv
// Shared types and default sizes for the Strassen multiplier and its result drain.
package strassen_pkg;

    localparam int N_DEF     = 16;
    localparam int DW_DEF    = 16;
    localparam int LANES_DEF = 4;

    typedef logic signed [DW_DEF-1:0] elem_t;
    typedef elem_t matrix_t [0:N_DEF-1][0:N_DEF-1];

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/strassen_result_drain.sv
// Snapshots the multiplier's NxN result on c_done and streams it row-major,
// LANES elements per valid/ready beat, so the multiplier can start the next product.
module strassen_result_drain
    import strassen_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N*N*DW-1:0]       c_in,
    input  logic                    c_done,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DW-1:0]     m_data,
    output logic [$clog2(N)-1:0]    m_row,
    output logic [$clog2(N)-1:0]    m_col,
    output logic                    m_last,
    output logic                    busy,
    output logic                    drain_done,
    output logic                    overrun,
    input  logic                    clr_overrun
);

    localparam int RW = $clog2(N);

    drain_state_t          state_q, state_d;
    logic [RW-1:0]         row_q, row_d, col_q, col_d;
    logic                  drain_done_q, drain_done_d;
    logic                  overrun_q, overrun_d;
    logic signed [DW-1:0]  buf_q [N][N];

    logic last_beat_s, accept_s, last_acc_s, capture_s;

    assign last_beat_s = (state_q == STREAM) && (row_q == RW'(N-1)) && (col_q == RW'(N-LANES));
    assign accept_s    = (state_q == STREAM) && m_ready;
    assign last_acc_s  = accept_s && last_beat_s;
    // A new result is taken when idle, or when the old one finishes in the same cycle.
    assign capture_s   = c_done && ((state_q == IDLE) || last_acc_s);

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            drain_done_q <= drain_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Snapshot buffer; contents are don't-care until the first capture
    always_ff @(posedge clk) begin
        if (capture_s) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_q[r][c] <= c_in[(r*N+c)*DW +: DW];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (c_done) state_d = STREAM;
                else        state_d = IDLE;
            end
            STREAM: begin
                if (last_acc_s && !c_done) state_d = IDLE;
                else                       state_d = STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat position, completion pulse and sticky overrun
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (capture_s) begin
            row_d = '0;
            col_d = '0;
        end else if (accept_s) begin
            if (col_q == RW'(N-LANES)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + RW'(LANES);
                row_d = row_q;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
        drain_done_d = last_acc_s;
        overrun_d    = (c_done && (state_q == STREAM) && !last_acc_s) ||
                       (overrun_q && !clr_overrun);
    end

    // Output decode from registered state and indices
    always_comb begin
        m_valid    = (state_q == STREAM);
        busy       = (state_q == STREAM);
        m_last     = last_beat_s;
        m_row      = row_q;
        m_col      = col_q;
        drain_done = drain_done_q;
        overrun    = overrun_q;
        m_data     = '0;
        if (state_q == STREAM) begin
            for (int k = 0; k < LANES; k++) begin
                m_data[k*DW +: DW] = buf_q[row_q][col_q + RW'(k)];
            end
        end else begin
            m_data = '0;
        end
    end

endmodule

// File: tb/tb_strassen_result_drain.sv
// Directed-sequence bench with randomized data/backpressure checked against a
// matrix-level model of the beat order.
module tb_strassen_result_drain;

    localparam int N = 16, DW = 16, LANES = 4, BEATS = N*N/LANES;

    logic                 clk = 1'b0;
    logic                 rst_n, c_done, m_ready, clr_overrun;
    logic [N*N*DW-1:0]    c_in;
    logic                 m_valid, m_last, busy, drain_done, overrun;
    logic [LANES*DW-1:0]  m_data;
    logic [3:0]           m_row, m_col;

    logic [15:0] src [N][N];
    logic [15:0] cur [N][N];
    logic [15:0] inj_val;
    logic        exp_ovr;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    strassen_result_drain dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .c_done(c_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last), .busy(busy),
        .drain_done(drain_done), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int b);
        logic [63:0] d;
        int r, c;
        r = b / 4;
        c = (b % 4) * 4;
        for (int k = 0; k < LANES; k++) d[k*16 +: 16] = cur[r][c+k];
        return d;
    endfunction

    task automatic start();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_in[(r*N+c)*DW +: DW] = src[r][c];
        cur = src;
        c_done = 1'b1;
        @(posedge clk); #1;
        c_done = 1'b0;
        chk("start_valid", {63'd0, m_valid}, 64'd1);
        chk("start_busy", {63'd0, busy}, 64'd1);
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready
    task automatic drain(input int mode, input int inj_at, input int rst_at);
        int  b = 0, cyc = 0;
        bit  injected = 1'b0;
        while (b < BEATS) begin
            if (cyc > 1000) begin
                chk("timeout", 64'd1, 64'd0);
                return;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            chk("valid", {63'd0, m_valid}, 64'd1);
            chk("busy", {63'd0, busy}, 64'd1);
            chk("row", {60'd0, m_row}, 64'(b / 4));
            chk("col", {60'd0, m_col}, 64'((b % 4) * 4));
            chk("data", m_data, exp_data(b));
            chk("last", {63'd0, m_last}, {63'd0, (b == BEATS-1)});
            if (b > 0) chk("dd_mid", {63'd0, drain_done}, 64'd0);
            if (b == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", {63'd0, m_valid}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_data", m_data, 64'd0);
                chk("rst_rowcol", {56'd0, m_row, m_col}, 64'd0);
                chk("rst_last", {63'd0, m_last}, 64'd0);
                chk("rst_ovr", {63'd0, overrun}, 64'd0);
                exp_ovr = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (b == inj_at && !injected) begin
                injected = 1'b1;
                c_in = {(N*N){inj_val}};
                c_done = 1'b1;
                if (!(b == BEATS-1 && m_ready)) exp_ovr = 1'b1;
            end
            @(posedge clk); #1;
            c_done = 1'b0;
            if (m_ready) b++;
            cyc++;
            chk("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
        end
        chk("drain_done", {63'd0, drain_done}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; c_done = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
        c_in = '0; exp_ovr = 1'b0; inj_val = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {63'd0, m_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_dd", {63'd0, drain_done}, 64'd0);
        chk("reset_ovr", {63'd0, overrun}, 64'd0);
        chk("reset_last", {63'd0, m_last}, 64'd0);
        chk("reset_rowcol", {56'd0, m_row, m_col}, 64'd0);
        chk("reset_data", m_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Incrementing matrix, ready always high
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 16'(r*16 + c);
        start();
        chk("t1_beat0", m_data, 64'h0003_0002_0001_0000);
        drain(0, -1, -1);
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);
        chk("t1_idle_valid", {63'd0, m_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t1_dd_pulse", {63'd0, drain_done}, 64'd0);

        // Same matrix with stalls
        start();
        drain(1, -1, -1);
        @(posedge clk); #1;

        // Negative values, random backpressure
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 16'(-(r*16 + c) - 1);
        start();
        chk("t3_beat0", m_data, 64'hFFFC_FFFD_FFFE_FFFF);
        drain(2, -1, -1);
        @(posedge clk); #1;

        // Overrun at beat 10, then clear
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 16'(r*16 + c);
        start();
        inj_val = 16'h7FFF;
        drain(0, 10, -1);
        chk("t4_ovr_sticky", {63'd0, overrun}, 64'd1);
        clr_overrun = 1'b1;
        exp_ovr = 1'b0;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        chk("t4_ovr_clr", {63'd0, overrun}, 64'd0);

        // Back-to-back capture on the final handshake
        start();
        inj_val = 16'h0001;
        drain(0, 63, -1);
        chk("t5_valid", {63'd0, m_valid}, 64'd1);
        chk("t5_rowcol", {56'd0, m_row, m_col}, 64'd0);
        chk("t5_data", m_data, 64'h0001_0001_0001_0001);
        chk("t5_ovr", {63'd0, overrun}, 64'd0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cur[r][c] = 16'h0001;
        drain(2, -1, -1);
        @(posedge clk); #1;

        // Reset mid-drain, then a fresh random matrix
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 16'($urandom);
        start();
        drain(0, -1, 20);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = 16'($urandom);
        start();
        drain(2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
